// File: rtl/ysyx_22050133_axi_master_if.sv
// Bus bundle for ysyx_22050133_axi_master: cache-side burst request port plus the AXI4 master channels.
// Signal suffixes are from the bridge's point of view; the environment uses the slave modport.
`timescale 1ns/1ps
interface ysyx_22050133_axi_master_if #(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH  = 4
);
  // cache-side request and data beats
  logic                       rw_addr_valid_i, rw_addr_ready_o;
  logic [RW_ADDR_WIDTH-1:0]   rw_addr_i;
  logic                       rw_we_i;
  logic [7:0]                 rw_len_i;
  logic [2:0]                 rw_size_i;
  logic [1:0]                 rw_burst_i;
  logic                       rw_if_i;
  logic                       w_data_valid_i, w_data_ready_o;
  logic [RW_DATA_WIDTH-1:0]   w_data_i;
  logic                       r_data_valid_o, r_data_ready_i;
  logic [RW_DATA_WIDTH-1:0]   r_data_o;

  // AXI4 channels
  logic                       axi_aw_valid_o, axi_aw_ready_i;
  logic [RW_ADDR_WIDTH-1:0]   axi_aw_addr_o;
  logic [AXI_ID_WIDTH-1:0]    axi_aw_id_o;
  logic [7:0]                 axi_aw_len_o;
  logic [2:0]                 axi_aw_size_o;
  logic [1:0]                 axi_aw_burst_o;
  logic [2:0]                 axi_aw_prot_o;
  logic                       axi_w_valid_o, axi_w_ready_i;
  logic [RW_DATA_WIDTH-1:0]   axi_w_data_o;
  logic [RW_DATA_WIDTH/8-1:0] axi_w_strb_o;
  logic                       axi_w_last_o;
  logic                       axi_b_valid_i, axi_b_ready_o;
  logic [1:0]                 axi_b_resp_i;
  logic [AXI_ID_WIDTH-1:0]    axi_b_id_i;
  logic                       axi_ar_valid_o, axi_ar_ready_i;
  logic [RW_ADDR_WIDTH-1:0]   axi_ar_addr_o;
  logic [AXI_ID_WIDTH-1:0]    axi_ar_id_o;
  logic [7:0]                 axi_ar_len_o;
  logic [2:0]                 axi_ar_size_o;
  logic [1:0]                 axi_ar_burst_o;
  logic [2:0]                 axi_ar_prot_o;
  logic                       axi_r_valid_i, axi_r_ready_o;
  logic [RW_DATA_WIDTH-1:0]   axi_r_data_i;
  logic [1:0]                 axi_r_resp_i;
  logic                       axi_r_last_i;
  logic [AXI_ID_WIDTH-1:0]    axi_r_id_i;

  modport master (
    input  rw_addr_valid_i, rw_addr_i, rw_we_i, rw_len_i, rw_size_i, rw_burst_i, rw_if_i,
    input  w_data_valid_i, w_data_i, r_data_ready_i,
    output rw_addr_ready_o, w_data_ready_o, r_data_valid_o, r_data_o,
    output axi_aw_valid_o, axi_aw_addr_o, axi_aw_id_o, axi_aw_len_o, axi_aw_size_o,
    output axi_aw_burst_o, axi_aw_prot_o,
    input  axi_aw_ready_i,
    output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
    input  axi_w_ready_i,
    input  axi_b_valid_i, axi_b_resp_i, axi_b_id_i,
    output axi_b_ready_o,
    output axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o, axi_ar_size_o,
    output axi_ar_burst_o, axi_ar_prot_o,
    input  axi_ar_ready_i,
    input  axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_id_i,
    output axi_r_ready_o
  );

  modport slave (
    output rw_addr_valid_i, rw_addr_i, rw_we_i, rw_len_i, rw_size_i, rw_burst_i, rw_if_i,
    output w_data_valid_i, w_data_i, r_data_ready_i,
    input  rw_addr_ready_o, w_data_ready_o, r_data_valid_o, r_data_o,
    input  axi_aw_valid_o, axi_aw_addr_o, axi_aw_id_o, axi_aw_len_o, axi_aw_size_o,
    input  axi_aw_burst_o, axi_aw_prot_o,
    output axi_aw_ready_i,
    input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
    output axi_w_ready_i,
    output axi_b_valid_i, axi_b_resp_i, axi_b_id_i,
    input  axi_b_ready_o,
    input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o, axi_ar_size_o,
    input  axi_ar_burst_o, axi_ar_prot_o,
    output axi_ar_ready_i,
    output axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_id_i,
    input  axi_r_ready_o
  );
endinterface

// File: rtl/ysyx_22050133_axi_master.sv
// Cache-to-AXI4 bridge: one single or INCR burst at a time, with lane alignment for narrow accesses.
// Optional response checking (sticky err_o) is enabled by defining YSYX_22050133_AXI_RESP_CHK_EN.
`timescale 1ns/1ps
module ysyx_22050133_axi_master #(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  ysyx_22050133_axi_master_if.master        bus,
  output logic                              err_o
);
  localparam int STRB_W = RW_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;

  state_e                   state_q;
  logic [RW_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]               len_q, cnt_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic                     if_q;
  logic [STRB_W-1:0]        strb_q, strb_d, strb_base;
  logic                     addr_ready_q, aw_valid_q, ar_valid_q, b_ready_q;

  logic                     in_w, in_r, last_beat, narrow;
  logic [5:0]               shamt;
  logic [AXI_ID_WIDTH-1:0]  id;
  logic                     req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign in_w      = (state_q == W);
  assign in_r      = (state_q == R);
  assign last_beat = (cnt_q == len_q);
  assign narrow    = (size_q < 3'd3);
  assign shamt     = {addr_q[2:0], 3'b000};
  assign id        = {{(AXI_ID_WIDTH-1){1'b0}}, if_q};

  assign req_hs = bus.rw_addr_valid_i && addr_ready_q;
  assign aw_hs  = aw_valid_q && bus.axi_aw_ready_i;
  assign w_hs   = bus.axi_w_valid_o && bus.axi_w_ready_i;
  assign b_hs   = b_ready_q && bus.axi_b_valid_i;
  assign ar_hs  = ar_valid_q && bus.axi_ar_ready_i;
  assign r_hs   = bus.axi_r_ready_o && bus.axi_r_valid_i;

  // Strobe is fixed for the whole transaction, so it is computed once at request time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    strb_base = '1;
    unique case (bus.rw_size_i)
      3'd0:    strb_base = STRB_W'(8'h01);
      3'd1:    strb_base = STRB_W'(8'h03);
      3'd2:    strb_base = STRB_W'(8'h0F);
      default: strb_base = '1;
    endcase
    strb_d = strb_base << bus.rw_addr_i[2:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      if_q         <= 1'b0;
      strb_q       <= '0;
      addr_ready_q <= 1'b1;
      aw_valid_q   <= 1'b0;
      ar_valid_q   <= 1'b0;
      b_ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_hs) begin
          addr_q       <= bus.rw_addr_i;
          len_q        <= bus.rw_len_i;
          size_q       <= bus.rw_size_i;
          burst_q      <= bus.rw_burst_i;
          if_q         <= bus.rw_if_i;
          strb_q       <= strb_d;
          cnt_q        <= '0;
          addr_ready_q <= 1'b0;
          aw_valid_q   <= bus.rw_we_i;
          ar_valid_q   <= !bus.rw_we_i;
          state_q      <= bus.rw_we_i ? AW : AR;
        end
        AW: if (aw_hs) begin
          aw_valid_q <= 1'b0;
          state_q    <= W;
        end
        W: if (w_hs) begin
          cnt_q <= cnt_q + 8'd1;
          if (last_beat) begin
            b_ready_q <= 1'b1;
            state_q   <= B;
          end
        end
        B: if (b_hs) begin
          b_ready_q    <= 1'b0;
          addr_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
        AR: if (ar_hs) begin
          ar_valid_q <= 1'b0;
          state_q    <= R;
        end
        R: if (r_hs) begin
          cnt_q <= cnt_q + 8'd1;
          // The slave's rlast always ends the read, even if it disagrees with the beat count.
          if (bus.axi_r_last_i) begin
            addr_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rw_addr_ready_o = addr_ready_q;

  assign bus.axi_aw_valid_o = aw_valid_q;
  assign bus.axi_aw_addr_o  = addr_q;
  assign bus.axi_aw_id_o    = id;
  assign bus.axi_aw_len_o   = len_q;
  assign bus.axi_aw_size_o  = size_q;
  assign bus.axi_aw_burst_o = burst_q;
  assign bus.axi_aw_prot_o  = {if_q, 2'b00};

  assign bus.axi_ar_valid_o = ar_valid_q;
  assign bus.axi_ar_addr_o  = addr_q;
  assign bus.axi_ar_id_o    = id;
  assign bus.axi_ar_len_o   = len_q;
  assign bus.axi_ar_size_o  = size_q;
  assign bus.axi_ar_burst_o = burst_q;
  assign bus.axi_ar_prot_o  = {if_q, 2'b00};

  // Data beats are combinational pass-throughs, gated to their own state.
  assign bus.axi_w_valid_o  = in_w && bus.w_data_valid_i;
  assign bus.w_data_ready_o = in_w && bus.axi_w_ready_i;
  assign bus.axi_w_data_o   = narrow ? (bus.w_data_i << shamt) : bus.w_data_i;
  assign bus.axi_w_strb_o   = strb_q;
  assign bus.axi_w_last_o   = in_w && last_beat;
  assign bus.axi_b_ready_o  = b_ready_q;

  assign bus.axi_r_ready_o  = in_r && bus.r_data_ready_i;
  assign bus.r_data_valid_o = in_r && bus.axi_r_valid_i;
  assign bus.r_data_o       = narrow ? (bus.axi_r_data_i >> shamt) : bus.axi_r_data_i;

`ifdef YSYX_22050133_AXI_RESP_CHK_EN
  logic err_q, b_bad, r_bad;

  assign b_bad = (bus.axi_b_resp_i != 2'b00) || (bus.axi_b_id_i != id);
  assign r_bad = (bus.axi_r_resp_i != 2'b00) || (bus.axi_r_id_i != id) ||
                 (bus.axi_r_last_i != last_beat);

  always_ff @(posedge clk) begin
    if (rst)                                  err_q <= 1'b0;
    else if ((b_hs && b_bad) || (r_hs && r_bad)) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050133_axi_master.sv
// Scoreboard bench for ysyx_22050133_axi_master: directed transactions push expected AW/AR/W/R
// items into queues; negedge monitors pop and compare whenever the bridge completes a handshake.
`timescale 1ns/1ps
module tb_ysyx_22050133_axi_master;
  logic clk = 1'b0;
  logic rst;
  logic err;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   r_bp = 1'b0;

`ifdef YSYX_22050133_AXI_RESP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [2:0]  prot;
  } addr_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } wbeat_t;

  addr_t       exp_aw[$];
  addr_t       exp_ar[$];
  wbeat_t      exp_w[$];
  logic [63:0] exp_r[$];

  ysyx_22050133_axi_master_if bus ();

  ysyx_22050133_axi_master dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .err_o (err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #400000;
    $display("FAIL watchdog: no summary after %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream read-ready: always high, or a 2-of-3 backpressure pattern when r_bp is set.
  initial forever begin
    tick();
    bus.r_data_ready_i = r_bp ? ((cyc % 3) != 0) : 1'b1;
  end

  // Monitors: compare every completed handshake against the head of its queue.
  initial begin
    addr_t a;
    wbeat_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.axi_aw_valid_o && bus.axi_aw_ready_i) begin
          check("aw_expected", exp_aw.size() != 0, 1);
          if (exp_aw.size() != 0) begin
            a = exp_aw.pop_front();
            check("aw_addr", bus.axi_aw_addr_o, a.addr);
            check("aw_len", bus.axi_aw_len_o, a.len);
            check("aw_size", bus.axi_aw_size_o, a.size);
            check("aw_burst", bus.axi_aw_burst_o, a.burst);
            check("aw_id", bus.axi_aw_id_o, a.id);
            check("aw_prot", bus.axi_aw_prot_o, a.prot);
          end
        end
        if (bus.axi_ar_valid_o && bus.axi_ar_ready_i) begin
          check("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) begin
            a = exp_ar.pop_front();
            check("ar_addr", bus.axi_ar_addr_o, a.addr);
            check("ar_len", bus.axi_ar_len_o, a.len);
            check("ar_size", bus.axi_ar_size_o, a.size);
            check("ar_burst", bus.axi_ar_burst_o, a.burst);
            check("ar_id", bus.axi_ar_id_o, a.id);
            check("ar_prot", bus.axi_ar_prot_o, a.prot);
          end
        end
        if (bus.axi_w_valid_o && bus.axi_w_ready_i) begin
          check("w_expected", exp_w.size() != 0, 1);
          if (exp_w.size() != 0) begin
            w = exp_w.pop_front();
            check("w_data", bus.axi_w_data_o, w.data);
            check("w_strb", bus.axi_w_strb_o, w.strb);
            check("w_last", bus.axi_w_last_o, w.last);
          end
        end
        if (bus.r_data_valid_o && bus.r_data_ready_i) begin
          check("r_expected", exp_r.size() != 0, 1);
          if (exp_r.size() != 0) check("r_data", bus.r_data_o, exp_r.pop_front());
        end
      end
    end
  end

  // Issue a request, wait (bounded) for acceptance, and confirm the address channel rises next cycle.
  task automatic req(input logic [31:0] a, input bit we, input logic [7:0] len,
                     input logic [2:0] size, input bit ifb, output int acc);
    int n = 0;
    bus.rw_addr_valid_i = 1'b1;
    bus.rw_addr_i  = a;
    bus.rw_we_i    = we;
    bus.rw_len_i   = len;
    bus.rw_size_i  = size;
    bus.rw_burst_i = 2'b01;
    bus.rw_if_i    = ifb;
    @(negedge clk);
    while (!bus.rw_addr_ready_o && n < 100) begin @(negedge clk); n++; end
    check("req_accepted", bus.rw_addr_ready_o, 1);
    tick();
    acc = cyc;
    bus.rw_addr_valid_i = 1'b0;
    if (we) check("aw_valid_after_req", bus.axi_aw_valid_o, 1);
    else    check("ar_valid_after_req", bus.axi_ar_valid_o, 1);
  endtask

  task automatic slave_addr(input bit is_wr, input int stall);
    repeat (stall) tick();
    if (is_wr) bus.axi_aw_ready_i = 1'b1;
    else       bus.axi_ar_ready_i = 1'b1;
    tick();
    bus.axi_aw_ready_i = 1'b0;
    bus.axi_ar_ready_i = 1'b0;
  endtask

  task automatic slave_r(input int nb, input logic [63:0] d0, input bit gaps, input logic [3:0] rid);
    for (int i = 0; i < nb; i++) begin
      int n = 0;
      if (gaps && (i % 2 == 1)) begin bus.axi_r_valid_i = 1'b0; tick(); end
      bus.axi_r_valid_i = 1'b1;
      bus.axi_r_data_i  = d0 + 64'(i);
      bus.axi_r_last_i  = (i == nb - 1);
      bus.axi_r_id_i    = rid;
      bus.axi_r_resp_i  = 2'b00;
      @(negedge clk);
      while (!bus.axi_r_ready_o && n < 100) begin @(negedge clk); n++; end
      check("r_beat_taken", bus.axi_r_ready_o, 1);
      tick();
    end
    bus.axi_r_valid_i = 1'b0;
    bus.axi_r_last_i  = 1'b0;
  endtask

  task automatic up_w(input int nb, input logic [63:0] d0, input logic [63:0] step, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      int n = 0;
      if (gaps && (i % 3 == 1)) begin bus.w_data_valid_i = 1'b0; tick(); end
      bus.w_data_valid_i = 1'b1;
      bus.w_data_i       = d0 + step * 64'(i);
      @(negedge clk);
      while (!bus.w_data_ready_o && n < 100) begin @(negedge clk); n++; end
      check("w_beat_taken", bus.w_data_ready_o, 1);
      tick();
    end
    bus.w_data_valid_i = 1'b0;
  endtask

  task automatic slave_w(input int stall);
    int n = 0;
    repeat (stall) tick();
    bus.axi_w_ready_i = 1'b1;
    @(negedge clk);
    while (!(bus.axi_w_valid_o && bus.axi_w_last_o) && n < 200) begin @(negedge clk); n++; end
    check("w_last_seen", bus.axi_w_valid_o && bus.axi_w_last_o, 1);
    tick();
    bus.axi_w_ready_i = 1'b0;
  endtask

  task automatic slave_b(input int dly, input logic [1:0] resp, output int b_cyc);
    int n = 0;
    repeat (dly) tick();
    bus.axi_b_valid_i = 1'b1;
    bus.axi_b_resp_i  = resp;
    bus.axi_b_id_i    = 4'd0;
    @(negedge clk);
    while (!bus.axi_b_ready_o && n < 100) begin @(negedge clk); n++; end
    check("b_ready_seen", bus.axi_b_ready_o, 1);
    tick();
    b_cyc = cyc;
    bus.axi_b_valid_i = 1'b0;
    bus.axi_b_resp_i  = 2'b00;
  endtask

  task automatic slave_idle();
    bus.axi_aw_ready_i = 1'b0; bus.axi_w_ready_i  = 1'b0; bus.axi_ar_ready_i = 1'b0;
    bus.axi_b_valid_i  = 1'b0; bus.axi_b_resp_i   = 2'b00; bus.axi_b_id_i    = 4'd0;
    bus.axi_r_valid_i  = 1'b0; bus.axi_r_data_i   = '0;    bus.axi_r_resp_i  = 2'b00;
    bus.axi_r_last_i   = 1'b0; bus.axi_r_id_i     = 4'd0;
  endtask

  initial begin
    int acc, acc2, bc;
    rst = 1'b1;
    slave_idle();
    bus.rw_addr_valid_i = 1'b0; bus.rw_addr_i = '0; bus.rw_we_i = 1'b0; bus.rw_len_i = '0;
    bus.rw_size_i = '0; bus.rw_burst_i = '0; bus.rw_if_i = 1'b0;
    bus.w_data_i = '0;
    // Hold upstream/slave valids high through reset: the bridge must still gate them off.
    bus.w_data_valid_i = 1'b1; bus.axi_r_valid_i = 1'b1; bus.axi_w_ready_i = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_addr_ready", bus.rw_addr_ready_o, 1);
    check("rst_aw_valid", bus.axi_aw_valid_o, 0);
    check("rst_ar_valid", bus.axi_ar_valid_o, 0);
    check("rst_w_valid", bus.axi_w_valid_o, 0);
    check("rst_w_data_ready", bus.w_data_ready_o, 0);
    check("rst_b_ready", bus.axi_b_ready_o, 0);
    check("rst_r_ready", bus.axi_r_ready_o, 0);
    check("rst_r_data_valid", bus.r_data_valid_o, 0);
    check("rst_fields", {bus.axi_aw_addr_o, bus.axi_aw_len_o, bus.axi_aw_size_o,
                         bus.axi_aw_burst_o, bus.axi_aw_id_o, bus.axi_aw_prot_o}, 0);
    check("rst_strb_last", {bus.axi_w_strb_o, bus.axi_w_last_o}, 0);
    check("rst_err", err, 0);
    bus.w_data_valid_i = 1'b0; bus.axi_r_valid_i = 1'b0; bus.axi_w_ready_i = 1'b0;
    tick();

    // 8-beat read, toggling rvalid and upstream backpressure
    r_bp = 1'b1;
    exp_ar.push_back('{32'h8000_0040, 8'd7, 3'd3, 2'b01, 4'd0, 3'b000});
    for (int i = 0; i < 8; i++) exp_r.push_back(64'(i));
    req(32'h8000_0040, 1'b0, 8'd7, 3'd3, 1'b0, acc);
    slave_addr(1'b0, 1);
    slave_r(8, 64'd0, 1'b1, 4'd0);
    check("rd8_ready_after_last", bus.rw_addr_ready_o, 1);
    r_bp = 1'b0;

    // 8-beat write, gapped upstream data and wready stalled 2 cycles
    exp_aw.push_back('{32'h8000_0080, 8'd7, 3'd3, 2'b01, 4'd0, 3'b000});
    for (int i = 0; i < 8; i++)
      exp_w.push_back('{64'hA5A5_0000_5A5A_0000 + 64'h0000_0001_0000_0001 * 64'(i), 8'hFF, i == 7});
    req(32'h8000_0080, 1'b1, 8'd7, 3'd3, 1'b0, acc);
    slave_addr(1'b1, 0);
    fork
      up_w(8, 64'hA5A5_0000_5A5A_0000, 64'h0000_0001_0000_0001, 1'b1);
      slave_w(2);
    join
    slave_b(1, 2'b00, bc);
    check("wr8_ready_after_b", bus.rw_addr_ready_o, 1);

    // 2-byte write at offset 6
    exp_aw.push_back('{32'h8000_0006, 8'd0, 3'd1, 2'b01, 4'd0, 3'b000});
    exp_w.push_back('{64'hBEEF_0000_0000_0000, 8'hC0, 1'b1});
    req(32'h8000_0006, 1'b1, 8'd0, 3'd1, 1'b0, acc);
    slave_addr(1'b1, 0);
    fork
      up_w(1, 64'h0000_0000_0000_BEEF, 64'd0, 1'b0);
      slave_w(0);
    join
    slave_b(0, 2'b00, bc);

    // Instruction-fetch read held off while the prior write sits in B
    exp_aw.push_back('{32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'd0, 3'b000});
    exp_w.push_back('{64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1});
    req(32'h8000_0100, 1'b1, 8'd0, 3'd3, 1'b0, acc);
    slave_addr(1'b1, 0);
    fork
      up_w(1, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
      slave_w(0);
    join
    exp_ar.push_back('{32'h8000_0200, 8'd0, 3'd3, 2'b01, 4'd1, 3'b100});
    exp_r.push_back(64'h0000_0000_0000_1234);
    fork
      begin
        @(negedge clk);
        check("ready_low_during_b", bus.rw_addr_ready_o, 0);
        slave_b(2, 2'b00, bc);
      end
      req(32'h8000_0200, 1'b0, 8'd0, 3'd3, 1'b1, acc2);
    join
    check("req_accept_after_b", 64'(acc2), 64'(bc + 1));
    slave_addr(1'b0, 0);
    slave_r(1, 64'h1234, 1'b0, 4'd1);
    check("err_clean_so_far", err, 0);

    // Write answered with SLVERR, then a 1-byte read to show err_o is sticky
    exp_aw.push_back('{32'h8000_0104, 8'd0, 3'd2, 2'b01, 4'd0, 3'b000});
    exp_w.push_back('{64'h1122_3344_0000_0000, 8'hF0, 1'b1});
    req(32'h8000_0104, 1'b1, 8'd0, 3'd2, 1'b0, acc);
    slave_addr(1'b1, 0);
    fork
      up_w(1, 64'h0000_0000_1122_3344, 64'd0, 1'b0);
      slave_w(0);
    join
    slave_b(0, 2'b10, bc);
    check("err_after_slverr", err, CHK);

    exp_ar.push_back('{32'h8000_0003, 8'd0, 3'd0, 2'b01, 4'd0, 3'b000});
    exp_r.push_back(64'h0000_0000_0000_00AB);
    req(32'h8000_0003, 1'b0, 8'd0, 3'd0, 1'b0, acc);
    slave_addr(1'b0, 0);
    slave_r(1, 64'h0000_0000_AB00_0000, 1'b0, 4'd0);
    check("err_sticky", err, CHK);

    // Reset in the middle of a 4-beat write
    exp_aw.push_back('{32'h8000_0300, 8'd3, 3'd3, 2'b01, 4'd0, 3'b000});
    exp_w.push_back('{64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0});
    req(32'h8000_0300, 1'b1, 8'd3, 3'd3, 1'b0, acc);
    slave_addr(1'b1, 0);
    bus.axi_w_ready_i  = 1'b1;
    bus.w_data_valid_i = 1'b1;
    bus.w_data_i       = 64'hDEAD_BEEF_0000_0001;
    tick();
    rst = 1'b1;
    slave_idle();
    tick();
    rst = 1'b0;
    check("midw_rst_addr_ready", bus.rw_addr_ready_o, 1);
    check("midw_rst_valids", {bus.axi_aw_valid_o, bus.axi_ar_valid_o, bus.axi_w_valid_o,
                              bus.w_data_ready_o, bus.axi_b_ready_o, bus.axi_r_ready_o,
                              bus.r_data_valid_o, bus.axi_w_last_o}, 0);
    check("midw_rst_err", err, 0);
    bus.w_data_valid_i = 1'b0;
    repeat (2) tick();

    check("sb_aw_drained", exp_aw.size(), 0);
    check("sb_ar_drained", exp_ar.size(), 0);
    check("sb_w_drained", exp_w.size(), 0);
    check("sb_r_drained", exp_r.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
